// File: rtl/hazard_tracker_pkg.sv
// Shared widths, MDU start encodings and default MDU latencies for the hazard tracker.
package hazard_tracker_pkg;

  localparam int TNEW_W          = 2;
  localparam int A3_W            = 5;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic [1:0] {
    MD_NONE = 2'b00,
    MD_MULT = 2'b01,
    MD_DIV  = 2'b10
  } md_start_e;

  typedef struct packed {
    logic [A3_W-1:0]   a3;
    logic              regwe;
    logic [TNEW_W-1:0] tnew;
  } tag_t;

  // Result readiness moves one cycle closer per stage but never goes below zero.
  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/hazard_tracker_if.sv
// Bundle of ID-stage request signals and per-stage destination tags for the hazard tracker.
interface hazard_tracker_if;
  import hazard_tracker_pkg::*;

  logic [A3_W-1:0]   IDA3;
  logic              IDRegWE;
  logic [TNEW_W-1:0] IDTnew;
  logic              stall;
  logic [1:0]        IDMDStart;
  logic              IDMDUse;

  logic [A3_W-1:0]   DEA3;
  logic              DERegWE;
  logic [TNEW_W-1:0] DETnew;
  logic [A3_W-1:0]   EMA3;
  logic              EMRegWE;
  logic [TNEW_W-1:0] EMTnew;
  logic [A3_W-1:0]   MWA3;
  logic              MWRegWE;
  logic [TNEW_W-1:0] MWTnew;
  logic              MDBusy;
  logic              stall_md;

  modport master (
    output IDA3, IDRegWE, IDTnew, stall, IDMDStart, IDMDUse,
    input  DEA3, DERegWE, DETnew, EMA3, EMRegWE, EMTnew,
           MWA3, MWRegWE, MWTnew, MDBusy, stall_md
  );

  modport slave (
    input  IDA3, IDRegWE, IDTnew, stall, IDMDStart, IDMDUse,
    output DEA3, DERegWE, DETnew, EMA3, EMRegWE, EMTnew,
           MWA3, MWRegWE, MWTnew, MDBusy, stall_md
  );

endinterface

// File: rtl/hazard_stage_reg.sv
// One pipeline-stage destination tag register with optional saturating Tnew decrement and bubble insertion.
module hazard_stage_reg
  import hazard_tracker_pkg::*;
#(
  parameter bit DECREMENT = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic bubble,
  input  tag_t din,
  output tag_t q
);

  tag_t nxt;

  // A tag naming register 0 never produces a hazard, so it collapses to an all-zero bubble.
  always_comb begin
    nxt = din;
    if (DECREMENT) begin
      nxt.tnew = tnew_dec(din.tnew);
    end
    if (bubble || (din.a3 == '0)) begin
      nxt = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// Tracks destination tags through D/E, E/M and M/W, plus MDU busy/stall when HAZARD_TRACKER_MDU_EN is defined.
module hazard_tracker
  import hazard_tracker_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              reset,
  hazard_tracker_if.slave   bus
);

  tag_t id_tag;
  tag_t de_tag;
  tag_t em_tag;
  tag_t mw_tag;

  assign id_tag = {bus.IDA3, bus.IDRegWE, bus.IDTnew};

  // D/E takes ID's Tnew as-is; later stages each age it by one cycle.
  hazard_stage_reg #(.DECREMENT(1'b0)) u_de (
    .clk    (clk),
    .reset  (reset),
    .bubble (bus.stall),
    .din    (id_tag),
    .q      (de_tag)
  );

  hazard_stage_reg #(.DECREMENT(1'b1)) u_em (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .din    (de_tag),
    .q      (em_tag)
  );

  hazard_stage_reg #(.DECREMENT(1'b1)) u_mw (
    .clk    (clk),
    .reset  (reset),
    .bubble (1'b0),
    .din    (em_tag),
    .q      (mw_tag)
  );

  assign bus.DEA3    = de_tag.a3;
  assign bus.DERegWE = de_tag.regwe;
  assign bus.DETnew  = de_tag.tnew;
  assign bus.EMA3    = em_tag.a3;
  assign bus.EMRegWE = em_tag.regwe;
  assign bus.EMTnew  = em_tag.tnew;
  assign bus.MWA3    = mw_tag.a3;
  assign bus.MWRegWE = mw_tag.regwe;
  assign bus.MWTnew  = mw_tag.tnew;

`ifdef HAZARD_TRACKER_MDU_EN
  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  md_start_e        de_md_start;
  logic [CNT_W-1:0] md_count;
  logic             md_busy;

  // The start code rides in D/E for one cycle, then the counter covers the remaining latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      de_md_start <= MD_NONE;
      md_count    <= '0;
    end else begin
      if (bus.stall) begin
        de_md_start <= MD_NONE;
      end else if (bus.IDMDStart == MD_MULT) begin
        de_md_start <= MD_MULT;
      end else if (bus.IDMDStart == MD_DIV) begin
        de_md_start <= MD_DIV;
      end else begin
        de_md_start <= MD_NONE;
      end

      case (de_md_start)
        MD_MULT: md_count <= CNT_W'(MULT_CYCLES);
        MD_DIV:  md_count <= CNT_W'(DIV_CYCLES);
        default: begin
          if (md_count != '0) begin
            md_count <= md_count - 1'b1;
          end
        end
      endcase
    end
  end

  assign md_busy      = (de_md_start != MD_NONE) || (md_count != '0);
  assign bus.MDBusy   = md_busy;
  assign bus.stall_md = bus.IDMDUse && md_busy;
`else
  logic unused_md;

  assign unused_md    = (^{bus.IDMDStart, bus.IDMDUse}) ^ (MULT_CYCLES > DIV_CYCLES);
  assign bus.MDBusy   = 1'b0;
  assign bus.stall_md = 1'b0;
`endif

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed bench for hazard_tracker: an issue-history model checked every cycle plus hand-computed pins.
module tb_hazard_tracker;
  import hazard_tracker_pkg::*;

`ifdef HAZARD_TRACKER_MDU_EN
  localparam int MDU_EN = 1;
`else
  localparam int MDU_EN = 0;
`endif
  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;

  hazard_tracker_if bus ();

  hazard_tracker #(.MULT_CYCLES(MULT_LAT), .DIV_CYCLES(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int passCount = 0;
  int checkCount = 0;
  bit checkEn = 1'b0;

  // Model: what ID issued k cycles ago, and how many more cycles the MDU stays busy.
  int hA3[1:3];
  int hWe[1:3];
  int hTnew[1:3];
  int mdRem = 0;

  initial begin
    for (int k = 1; k <= 3; k++) begin
      hA3[k] = 0; hWe[k] = 0; hTnew[k] = 0;
    end
  end

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= 3; k++) begin
        hA3[k] = 0; hWe[k] = 0; hTnew[k] = 0;
      end
      mdRem = 0;
    end else begin
      for (int k = 3; k > 1; k--) begin
        hA3[k] = hA3[k-1]; hWe[k] = hWe[k-1]; hTnew[k] = hTnew[k-1];
      end
      if (bus.stall) begin
        hA3[1] = 0; hWe[1] = 0; hTnew[1] = 0;
      end else begin
        hA3[1] = int'(bus.IDA3); hWe[1] = int'(bus.IDRegWE); hTnew[1] = int'(bus.IDTnew);
      end
      if (MDU_EN != 0 && !bus.stall && bus.IDMDStart == 2'b01) mdRem = MULT_LAT + 1;
      else if (MDU_EN != 0 && !bus.stall && bus.IDMDStart == 2'b10) mdRem = DIV_LAT + 1;
      else if (mdRem > 0) mdRem = mdRem - 1;
    end
  end

  function automatic int expWe(int k);
    return (hA3[k] != 0 && hWe[k] != 0) ? 1 : 0;
  endfunction

  function automatic int expTnew(int k);
    int t;
    t = hTnew[k] - (k - 1);
    if (hA3[k] == 0 || t < 0) t = 0;
    return t;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checkCount++;
    if (act == exp) passCount++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic checkOutput();
    int busy;
    busy = (mdRem > 0) ? 1 : 0;
    check("DEA3",    int'(bus.DEA3),    hA3[1]);
    check("DERegWE", int'(bus.DERegWE), expWe(1));
    check("DETnew",  int'(bus.DETnew),  expTnew(1));
    check("EMA3",    int'(bus.EMA3),    hA3[2]);
    check("EMRegWE", int'(bus.EMRegWE), expWe(2));
    check("EMTnew",  int'(bus.EMTnew),  expTnew(2));
    check("MWA3",    int'(bus.MWA3),    hA3[3]);
    check("MWRegWE", int'(bus.MWRegWE), expWe(3));
    check("MWTnew",  int'(bus.MWTnew),  expTnew(3));
    check("MDBusy",  int'(bus.MDBusy),  busy);
    check("stall_md", int'(bus.stall_md), (bus.IDMDUse && busy != 0) ? 1 : 0);
  endtask

  always @(negedge clk) begin
    if (checkEn) checkOutput();
  end

  // Inputs change just after the falling edge so the compare process sees them settled.
  task automatic applyStimulus(input logic r, input logic [4:0] a3, input logic we,
                               input logic [1:0] tnew, input logic st,
                               input logic [1:0] mds, input logic mdu);
    #1;
    reset = r;
    bus.IDA3 = a3;
    bus.IDRegWE = we;
    bus.IDTnew = tnew;
    bus.stall = st;
    bus.IDMDStart = mds;
    bus.IDMDUse = mdu;
    @(negedge clk);
  endtask

  task automatic idle(input logic mdu);
    applyStimulus(1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 2'b00, mdu);
  endtask

  typedef struct { logic [4:0] a3; logic we; logic [1:0] tnew; logic st; } vec_t;
  vec_t vecs[8];
  int busyCycles;

  initial begin
    bus.IDA3 = 5'd0; bus.IDRegWE = 1'b0; bus.IDTnew = 2'd0;
    bus.stall = 1'b0; bus.IDMDStart = 2'b00; bus.IDMDUse = 1'b0;
    checkEn = 1'b1;

    // Reset wins over every other input.
    applyStimulus(1'b1, 5'd9, 1'b1, 2'd2, 1'b0, 2'b01, 1'b1);
    applyStimulus(1'b1, 5'd9, 1'b1, 2'd2, 1'b1, 2'b10, 1'b1);
    check("rstDEA3", int'(bus.DEA3), 0);
    check("rstMDBusy", int'(bus.MDBusy), 0);
    check("rstStallMd", int'(bus.stall_md), 0);

    applyStimulus(1'b0, 5'd8, 1'b1, 2'd2, 1'b0, 2'b00, 1'b0);
    check("pinDEA3", int'(bus.DEA3), 8);
    check("pinDETnew", int'(bus.DETnew), 2);
    check("pinDERegWE", int'(bus.DERegWE), 1);
    idle(1'b0);
    check("pinEMA3", int'(bus.EMA3), 8);
    check("pinEMTnew", int'(bus.EMTnew), 1);
    idle(1'b0);
    check("pinMWA3", int'(bus.MWA3), 8);
    check("pinMWTnew", int'(bus.MWTnew), 0);
    check("pinMWRegWE", int'(bus.MWRegWE), 1);

    applyStimulus(1'b0, 5'd0, 1'b1, 2'd2, 1'b0, 2'b00, 1'b0);
    check("zeroDERegWE", int'(bus.DERegWE), 0);
    check("zeroDETnew", int'(bus.DETnew), 0);

    applyStimulus(1'b0, 5'd12, 1'b1, 2'd2, 1'b0, 2'b00, 1'b0);
    applyStimulus(1'b0, 5'd5, 1'b1, 2'd1, 1'b1, 2'b00, 1'b0);
    check("bubDEA3", int'(bus.DEA3), 0);
    check("bubDERegWE", int'(bus.DERegWE), 0);
    check("bubEMA3", int'(bus.EMA3), 12);
    check("bubEMTnew", int'(bus.EMTnew), 1);

    vecs[0] = '{5'd31, 1'b1, 2'd1, 1'b0};
    vecs[1] = '{5'd3,  1'b0, 2'd2, 1'b0};
    vecs[2] = '{5'd7,  1'b1, 2'd0, 1'b0};
    vecs[3] = '{5'd9,  1'b1, 2'd2, 1'b1};
    vecs[4] = '{5'd20, 1'b1, 2'd2, 1'b0};
    vecs[5] = '{5'd1,  1'b1, 2'd1, 1'b0};
    vecs[6] = '{5'd2,  1'b1, 2'd2, 1'b1};
    vecs[7] = '{5'd17, 1'b1, 2'd2, 1'b0};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, vecs[i].a3, vecs[i].we, vecs[i].tnew, vecs[i].st, 2'b00, 1'b0);
    end
    for (int i = 0; i < 3; i++) idle(1'b0);

    // Multiply: one cycle of latched start plus the multiply latency.
    applyStimulus(1'b0, 5'd4, 1'b1, 2'd1, 1'b0, 2'b01, 1'b0);
    check("mulFirst", int'(bus.MDBusy), MDU_EN);
    busyCycles = int'(bus.MDBusy);
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      busyCycles += int'(bus.MDBusy);
    end
    check("mulBusyLen", busyCycles, (MDU_EN != 0) ? 6 : 0);

    applyStimulus(1'b0, 5'd6, 1'b1, 2'd2, 1'b0, 2'b10, 1'b0);
    busyCycles = int'(bus.MDBusy);
    for (int i = 0; i < 14; i++) begin
      idle(1'b1);
      busyCycles += int'(bus.MDBusy);
    end
    check("divBusyLen", busyCycles, (MDU_EN != 0) ? 11 : 0);

    applyStimulus(1'b0, 5'd6, 1'b1, 2'd2, 1'b1, 2'b01, 1'b1);
    check("stallNoStart", int'(bus.MDBusy), 0);
    applyStimulus(1'b0, 5'd6, 1'b1, 2'd2, 1'b0, 2'b11, 1'b1);
    check("resvNoStart", int'(bus.MDBusy), 0);

    // A second start two cycles into a multiply reloads the counter.
    applyStimulus(1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 2'b01, 1'b0);
    busyCycles = int'(bus.MDBusy);
    idle(1'b0); busyCycles += int'(bus.MDBusy);
    idle(1'b0); busyCycles += int'(bus.MDBusy);
    applyStimulus(1'b0, 5'd0, 1'b0, 2'd0, 1'b0, 2'b01, 1'b0);
    busyCycles += int'(bus.MDBusy);
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      busyCycles += int'(bus.MDBusy);
    end
    check("restartBusyLen", busyCycles, (MDU_EN != 0) ? 9 : 0);

    // Divide aborted by reset with three cycles left on the counter.
    applyStimulus(1'b0, 5'd11, 1'b1, 2'd2, 1'b0, 2'b10, 1'b1);
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("preRstBusy", int'(bus.MDBusy), MDU_EN);
    applyStimulus(1'b1, 5'd13, 1'b1, 2'd2, 1'b1, 2'b01, 1'b1);
    check("rstAbortBusy", int'(bus.MDBusy), 0);
    check("rstAbortStallMd", int'(bus.stall_md), 0);
    idle(1'b1);
    check("postRstBusy", int'(bus.MDBusy), 0);
    for (int i = 0; i < 3; i++) idle(1'b0);

    checkEn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/hazard_tracker.md
HAZARD_TRACKER -- requirements
Module: hazard_tracker

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning busy cycles for a multiply.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning busy cycles for a divide.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 IDA3  input  5  destination register of the instruction in ID.
REQ-006 IDRegWE  input  1  ID instruction writes the register file.
REQ-007 IDTnew  input  2  cycles from E-entry until the ID result is ready, range 0..2.
REQ-008 stall  input  1  hazard stall for the ID instruction this cycle.
REQ-009 IDMDStart  input  2  00 none, 01 multiply, 10 divide, 11 reserved (treated as none).
REQ-010 IDMDUse  input  1  ID instruction reads or writes HI/LO or starts the MDU.
REQ-011 DEA3/DERegWE/DETnew  output  5/1/2  D/E-stage destination tag.
REQ-012 EMA3/EMRegWE/EMTnew  output  5/1/2  E/M-stage destination tag.
REQ-013 MWA3/MWRegWE/MWTnew  output  5/1/2  M/W-stage destination tag.
REQ-014 MDBusy  output  1  MDU occupied.
REQ-015 stall_md  output  1  ID must stall on the MDU.

Function
REQ-016 SHALL register all tag outputs directly, with no combinational path from inputs to tag outputs.
REQ-017 When stall=0, SHALL load D/E each edge with A3=IDA3, RegWE=IDRegWE&&(IDA3!=0), Tnew=IDTnew.
REQ-018 When stall=1, SHALL load D/E with the bubble A3=0, RegWE=0, Tnew=0, and no MDU start.
REQ-019 SHALL load E/M from D/E and M/W from E/M every cycle, including stall cycles.
REQ-020 On each stage advance, SHALL compute next Tnew as a saturating decrement: 0->0, 1->0, 2->1.
REQ-021 SHALL force Tnew=0 and RegWE=0 in any stage whose stored A3=0.
REQ-022 SHALL latch the MDU start in D/E as DEMDStart; a bubble and the code 11 both load 00.
REQ-023 Busy counter (width to hold max(MULT_CYCLES,DIV_CYCLES)): DEMDStart=01 loads MULT_CYCLES, 10 loads DIV_CYCLES; otherwise decrements when nonzero.
REQ-024 SHALL assert MDBusy = (DEMDStart!=00) || (counter!=0).
REQ-025 SHALL assert stall_md = IDMDUse && MDBusy, combinationally.
REQ-026 A start arriving while the counter is nonzero SHALL reload the counter; stall_md is what prevents this case in normal operation.

Reset
REQ-027 On reset, SHALL clear every stage to A3=0, RegWE=0, Tnew=0, DEMDStart=00, and counter=0; MDBusy=0 and stall_md=0 in the following cycle.
REQ-028 Reset SHALL take priority over stall and every other input; reset in mid-MDU-operation SHALL abort the count immediately.

Configuration
REQ-029 Macro HAZARD_TRACKER_MDU_EN: when defined, the MDU busy logic of REQ-022..026 SHALL be present.
REQ-030 When the macro is undefined, SHALL omit the counter and DEMDStart, tie MDBusy=0 and stall_md=0, and ignore IDMDStart and IDMDUse; tag behaviour SHALL be unchanged.

Structure
REQ-031 Shared package SHALL hold Tnew width 2, register-address width 5, the MDStart encodings (NONE/MULT/DIV), and the defaults for MULT_CYCLES and DIV_CYCLES.
REQ-032 SHALL instantiate one sub-module, hazard_stage_reg, three times, one per stage: tag register with saturating Tnew decrement and bubble input.

Verification
REQ-033 Reset, then IDA3=8, IDRegWE=1, IDTnew=2, stall=0 for one cycle -> DETnew=2, then EMTnew=1, then MWTnew=0, with A3=8 tracked through all stages.
REQ-034 IDA3=0, IDRegWE=1, IDTnew=2 -> DERegWE=0 and DETnew=0.
REQ-035 stall=1 with IDA3=5 -> D/E holds a bubble (0/0/0) while the prior D/E contents appear in E/M on the same edge.
REQ-036 MDU_EN: IDMDStart=01, then IDMDUse=1 -> MDBusy high for 1+5 cycles and stall_md tracks it; a divide gives 1+10 cycles.
REQ-037 MDU_EN: reset asserted with the counter at 3 -> MDBusy=0 on the next cycle; without the macro, MDBusy=0 for any start.
